// File: rtl/vga_pkg.sv
// Shared video-timing definitions: standard mode constants, sync polarity
// encodings and the display-side signal bundle carried down the fetch-lead
// delay line.
package vga_pkg;

  // Sync polarity encodings for the H_POL / V_POL parameters.
  localparam int unsigned POL_ACTIVE_LOW  = 0;
  localparam int unsigned POL_ACTIVE_HIGH = 1;

  // 1024x768 @ 70 Hz (75 MHz pixel clock).
  localparam int unsigned M1024_H_VIS  = 1024;
  localparam int unsigned M1024_H_FP   = 24;
  localparam int unsigned M1024_H_SYNC = 136;
  localparam int unsigned M1024_H_BP   = 144;
  localparam int unsigned M1024_V_VIS  = 768;
  localparam int unsigned M1024_V_FP   = 3;
  localparam int unsigned M1024_V_SYNC = 6;
  localparam int unsigned M1024_V_BP   = 29;
  localparam int unsigned M1024_H_POL  = POL_ACTIVE_LOW;
  localparam int unsigned M1024_V_POL  = POL_ACTIVE_LOW;

  // 800x600 @ 60 Hz (40 MHz pixel clock).
  localparam int unsigned M800_H_VIS  = 800;
  localparam int unsigned M800_H_FP   = 40;
  localparam int unsigned M800_H_SYNC = 128;
  localparam int unsigned M800_H_BP   = 88;
  localparam int unsigned M800_V_VIS  = 600;
  localparam int unsigned M800_V_FP   = 1;
  localparam int unsigned M800_V_SYNC = 4;
  localparam int unsigned M800_V_BP   = 23;
  localparam int unsigned M800_H_POL  = POL_ACTIVE_HIGH;
  localparam int unsigned M800_V_POL  = POL_ACTIVE_HIGH;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock).
  localparam int unsigned M640_H_VIS  = 640;
  localparam int unsigned M640_H_FP   = 16;
  localparam int unsigned M640_H_SYNC = 96;
  localparam int unsigned M640_H_BP   = 48;
  localparam int unsigned M640_V_VIS  = 480;
  localparam int unsigned M640_V_FP   = 10;
  localparam int unsigned M640_V_SYNC = 2;
  localparam int unsigned M640_V_BP   = 33;
  localparam int unsigned M640_H_POL  = POL_ACTIVE_LOW;
  localparam int unsigned M640_V_POL  = POL_ACTIVE_LOW;

  // Display-side signals; syncs are held active-high here and polarity is
  // applied only at the output pins.
  typedef struct packed {
    logic avr;
    logic h_sync;
    logic v_sync;
    logic line_start;
    logic frame_start;
  } disp_t;

  localparam disp_t DISP_IDLE = '0;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..TOTAL-1 while enabled, flags the last count
// (wrap), and decodes the visible / sync phase of the count it will hold
// after this clock so the parent can register the decode in step with it.
module vga_axis_counter #(
  parameter int unsigned TOTAL      = 16,
  parameter int unsigned VIS        = 8,
  parameter int unsigned SYNC_START = 10,
  parameter int unsigned SYNC_END   = 13,
  parameter int unsigned CW         = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_ce,
  output logic [CW-1:0] o_count,
  output logic          o_wrap,
  output logic          o_nxt_vis,
  output logic          o_nxt_sync
);

  localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] VIS_C  = CW'(VIS);
  localparam logic [CW-1:0] SYNC_S = CW'(SYNC_START);
  localparam logic [CW-1:0] SYNC_E = CW'(SYNC_END);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_nxt;

  assign o_wrap = (r_count == LAST);

  // Next count: advance when enabled, wrapping after the last position.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    w_nxt = r_count;
    if (i_ce) begin
      w_nxt = o_wrap ? '0 : r_count + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) r_count <= '0;
    else        r_count <= w_nxt;
  end

  assign o_count    = r_count;
  assign o_nxt_vis  = (w_nxt < VIS_C);
  assign o_nxt_sync = (w_nxt >= SYNC_S) && (w_nxt < SYNC_E);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator. Fetch-side coordinates come straight
// from the axis counters; the display-side bundle (avr, syncs, start pulses)
// is a registered decode delayed by FETCH_LAT ce-qualified stages so the
// framebuffer read has that many pixels of lead.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS     = M1024_H_VIS,
  parameter int unsigned H_FP      = M1024_H_FP,
  parameter int unsigned H_SYNC    = M1024_H_SYNC,
  parameter int unsigned H_BP      = M1024_H_BP,
  parameter int unsigned V_VIS     = M1024_V_VIS,
  parameter int unsigned V_FP      = M1024_V_FP,
  parameter int unsigned V_SYNC    = M1024_V_SYNC,
  parameter int unsigned V_BP      = M1024_V_BP,
  parameter int unsigned H_POL     = M1024_H_POL,
  parameter int unsigned V_POL     = M1024_V_POL,
  parameter int unsigned FETCH_LAT = 0,
  parameter int unsigned CW        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  output logic          h_sync,
  output logic          v_sync,
  output logic          avr,
  output logic [CW-1:0] pixel_num,
  output logic [CW-1:0] line_num,
  output logic          fetch_avr,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic        H_LVL   = (H_POL != 0);
  localparam logic        V_LVL   = (V_POL != 0);

  // Reject modes the counters or delay line cannot represent.
  if (CW < 1 || CW > 30 || H_TOTAL > (32'd1 << CW) || V_TOTAL > (32'd1 << CW)) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end
  if (FETCH_LAT > 7) begin : g_bad_lat
    $error("vga_timing_gen: FETCH_LAT must be 0..7");
  end

  logic [CW-1:0] w_hc;
  logic [CW-1:0] w_vc;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_h_vis_nxt;
  logic          w_h_sync_nxt;
  logic          w_v_vis_nxt;
  logic          w_v_sync_nxt;
  logic          w_v_ce;
  disp_t         w_decode;

  // The vertical axis steps once per completed line.
  assign w_v_ce = ce & w_h_wrap;

  vga_axis_counter #(
    .TOTAL     (H_TOTAL),
    .VIS       (H_VIS),
    .SYNC_START(H_VIS + H_FP),
    .SYNC_END  (H_VIS + H_FP + H_SYNC),
    .CW        (CW)
  ) u_h_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ce      (ce),
    .o_count   (w_hc),
    .o_wrap    (w_h_wrap),
    .o_nxt_vis (w_h_vis_nxt),
    .o_nxt_sync(w_h_sync_nxt)
  );

  vga_axis_counter #(
    .TOTAL     (V_TOTAL),
    .VIS       (V_VIS),
    .SYNC_START(V_VIS + V_FP),
    .SYNC_END  (V_VIS + V_FP + V_SYNC),
    .CW        (CW)
  ) u_v_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ce      (w_v_ce),
    .o_count   (w_vc),
    .o_wrap    (w_v_wrap),
    .o_nxt_vis (w_v_vis_nxt),
    .o_nxt_sync(w_v_sync_nxt)
  );

  // Decode of the position the counters move to on this ce. The stage is
  // only loaded when ce=1, so "next is pixel 0" is exactly the wrap flag.
  always_comb begin
    w_decode             = DISP_IDLE;
    w_decode.avr         = w_h_vis_nxt & w_v_vis_nxt;
    w_decode.h_sync      = w_h_sync_nxt;
    w_decode.v_sync      = w_v_sync_nxt;
    w_decode.line_start  = w_h_wrap;
    w_decode.frame_start = w_h_wrap & w_v_wrap;
  end

  // Stage 0 tracks the fetch counters; stages 1..FETCH_LAT delay it by ce's.
  disp_t r_pipe [0:FETCH_LAT];

  // Registered decode plus ce-qualified fetch-lead delay line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the delay line is explicitly cleared so a restart never replays a stale or partial sync pulse.
      for (int k = 0; k <= int'(FETCH_LAT); k++) r_pipe[k] <= DISP_IDLE;
    end else if (ce) begin
      r_pipe[0] <= w_decode;
      for (int k = 1; k <= int'(FETCH_LAT); k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign pixel_num   = w_hc;
  assign line_num    = w_vc;
  assign fetch_avr   = r_pipe[0].avr;
  assign avr         = r_pipe[FETCH_LAT].avr;
  assign h_sync      = r_pipe[FETCH_LAT].h_sync ? H_LVL : ~H_LVL;
  assign v_sync      = r_pipe[FETCH_LAT].v_sync ? V_LVL : ~V_LVL;
  assign line_start  = r_pipe[FETCH_LAT].line_start;
  assign frame_start = r_pipe[FETCH_LAT].frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Two instances of a 16x8 mode run in
// lockstep: A with active-low syncs and no fetch lead, B with active-high
// syncs and a 3-pixel lead. The reference model tracks only how many ce's
// have elapsed since reset and derives every output from the timing rules.
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 3;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;  // 16
  localparam int VT = VV + VF + VS + VB;  // 8
  localparam int FT = HT * VT;            // 128
  localparam int LAT_B = 3;

  typedef struct {
    int pix;
    int line;
    bit favr;
    bit avr;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  logic       hs_a, vs_a, avr_a, favr_a, ls_a, fs_a;
  logic [3:0] pix_a, line_a;
  logic       hs_b, vs_b, avr_b, favr_b, ls_b, fs_b;
  logic [3:0] pix_b, line_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ce     = 0;   // ce's since reset (model state)
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(0), .V_POL(0), .FETCH_LAT(0), .CW(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .h_sync(hs_a), .v_sync(vs_a), .avr(avr_a),
    .pixel_num(pix_a), .line_num(line_a), .fetch_avr(favr_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1), .V_POL(1), .FETCH_LAT(LAT_B), .CW(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .h_sync(hs_b), .v_sync(vs_b), .avr(avr_b),
    .pixel_num(pix_b), .line_num(line_b), .fetch_avr(favr_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  // Reference: fetch side shows position n mod FT; display side shows the
  // position lat ce's behind, or an idle bundle until that position exists.
  function automatic exp_t model(int n, int lat, bit pol);
    exp_t e;
    int pos, d, h, v;
    bit hs_act, vs_act;
    pos    = n % FT;
    e.pix  = pos % HT;
    e.line = pos / HT;
    e.favr = (n >= 1) && (e.pix < HV) && (e.line < VV);
    d      = n - lat;
    e.avr  = 1'b0;
    e.ls   = 1'b0;
    e.fs   = 1'b0;
    hs_act = 1'b0;
    vs_act = 1'b0;
    if (d >= 1) begin
      h      = (d % FT) % HT;
      v      = (d % FT) / HT;
      e.avr  = (h < HV) && (v < VV);
      hs_act = (h >= HV + HF) && (h < HV + HF + HS);
      vs_act = (v >= VV + VF) && (v < VV + VF + VS);
      e.ls   = (h == 0);
      e.fs   = (h == 0) && (v == 0);
    end
    e.hs = pol ? hs_act : !hs_act;
    e.vs = pol ? vs_act : !vs_act;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e,
                         input logic [3:0] pix, input logic [3:0] line,
                         input logic favr, input logic av, input logic hs,
                         input logic vs, input logic ls, input logic fs);
    check({tag, ".pixel_num"},   32'(pix),  32'(e.pix));
    check({tag, ".line_num"},    32'(line), 32'(e.line));
    check({tag, ".fetch_avr"},   32'(favr), 32'(e.favr));
    check({tag, ".avr"},         32'(av),   32'(e.avr));
    check({tag, ".h_sync"},      32'(hs),   32'(e.hs));
    check({tag, ".v_sync"},      32'(vs),   32'(e.vs));
    check({tag, ".line_start"},  32'(ls),   32'(e.ls));
    check({tag, ".frame_start"}, 32'(fs),   32'(e.fs));
  endtask

  // Drive one clock of stimulus, advance the model and queue expectations.
  task automatic step(input bit r, input bit c);
    @(negedge clk);
    rst_n = r;
    ce    = c;
    @(posedge clk);
    if (!r)     n_ce = 0;
    else if (c) n_ce++;
    q_a.push_back(model(n_ce, 0, 1'b0));
    q_b.push_back(model(n_ce, LAT_B, 1'b1));
  endtask

  // Monitor: outputs are presented every clock; compare just after the edge.
  initial begin
    exp_t ea, eb;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0 && q_b.size() > 0) begin
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        compare("A", ea, pix_a, line_a, favr_a, avr_a, hs_a, vs_a, ls_a, fs_a);
        compare("B", eb, pix_b, line_b, favr_b, avr_b, hs_b, vs_b, ls_b, fs_b);
      end
    end
  end

  // Stimulus.
  initial begin
    int guard;
    // Reset held with ce=1: reset must win.
    repeat (3) step(1'b0, 1'b1);
    // Continuous ce: a little over two frames.
    repeat (2 * FT + 40) step(1'b1, 1'b1);
    // ce alternating 1,0: frame period doubles, pulses stretch to 2 clks.
    for (int i = 0; i < 2 * FT + 20; i++) step(1'b1, (i % 2) == 0);
    // Random ce density with occasional random resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0));
    end
    // Reset mid-frame at hc=5, vc=2 held for two clocks.
    guard = 0;
    while (((n_ce % FT) != (2 * HT + 5)) && guard < 2 * FT) begin
      step(1'b1, 1'b1);
      guard++;
    end
    check("reach_hc5_vc2", 32'(n_ce % FT), 32'(2 * HT + 5));
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (FT + 20) step(1'b1, 1'b1);
    // Let the monitor drain the last expectation.
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(q_a.size() + q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the stimulus is clock-counted, so this only trips on a stall.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised video timing generator; successor to the fixed 1024x768@70Hz generator. Produces horizontal and vertical sync, an active-video strobe, and pixel/line coordinates for any mode set by parameters. Adds programmable sync polarity, a pixel clock-enable for divided pixel rates, frame/line start pulses, and a fetch-lead: coordinates run FETCH_LAT pixels ahead of sync/avr to cover framebuffer read latency. Sits between the pixel clock domain and the framebuffer address generator / DAC.

Parameters:
H_VIS, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 144, horizontal back porch (pixels)
V_VIS, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines)
H_POL, 0, h_sync active level (0 = active-low, 1 = active-high)
V_POL, 0, v_sync active level
FETCH_LAT, 0, pixel lead of coordinates over sync/avr (0..7)
CW, 11, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel-domain clock
rst_n  in  1  synchronous reset, active-low
ce  in  1  pixel advance enable; tie 1 for one pixel per clk
h_sync  out  1  horizontal sync, polarity per H_POL
v_sync  out  1  vertical sync, polarity per V_POL
avr  out  1  active video region (pixel in visible area)
pixel_num  out  CW  fetch-side horizontal count, 0..H_TOTAL-1
line_num  out  CW  fetch-side vertical count, 0..V_TOTAL-1
fetch_avr  out  1  fetch-side active region (pixel_num<H_VIS and line_num<V_VIS)
line_start  out  1  one-ce pulse, display-side count at pixel 0 of any line
frame_start  out  1  one-ce pulse, display-side count at pixel 0 of line 0

Behaviour:
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: visible, front porch, sync, back porch.
- Fetch counters hc, vc: on clk with ce=1, hc increments; at hc=H_TOTAL-1, hc wraps to 0 and vc increments; at vc=V_TOTAL-1 with hc wrap, vc wraps to 0. ce=0: all state and outputs hold.
- pixel_num=hc, line_num=vc, fetch_avr decoded from the registered hc/vc; no combinational path from ce.
- Display-side signals are a registered decode of (hc,vc), delayed by FETCH_LAT ce-qualified stages (shift register advances only when ce=1). FETCH_LAT=0: display signals align with pixel_num/line_num in the same cycle.
- Display decode: avr = h<H_VIS and v<V_VIS; h_sync active when H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC; v_sync active when V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC for the whole line, changing at the line wrap (h=0). Inactive level = ~POL.
- line_start=1 for the ce-period where display h=0; frame_start additionally requires v=0.
- Reset (rst_n=0 at clk edge, takes priority over ce): hc=vc=0, delay stages cleared to the (0,0) decode being invalid: avr=0, fetch_avr=0, syncs inactive, pulses 0. The first ce after reset release yields pixel (0,0) on the fetch side; display side reports (0,0) after FETCH_LAT further ce's, with avr/syncs inactive until then. Reset mid-frame restarts at (0,0) with no partial sync pulse.
- Elaboration error (generate-time check) if CW is too narrow for the totals, if any porch/sync parameter is 0, or if FETCH_LAT>7.

Decomposition:
- Shared package vga_pkg: mode constants for 1024x768@70, 800x600@60, 640x480@60 (per-field localparams), polarity encodings.
- One sub-module: vga_axis_counter (count 0..TOTAL-1 with ce, wrap strobe, phase decode for visible/sync), instanced once for horizontal and once for vertical (vertical ce = ce & h wrap).

Test Plan:
- Small mode H 8/2/3/3 (total 16), V 4/1/2/1 (total 8), pols 0, FETCH_LAT=0, ce=1 -> frame period 128 clks; avr high 32 clks/frame; h_sync low for hc 10..12; v_sync low for lines 5..6; frame_start every 128 clks.
- Same mode, H_POL=1, V_POL=1 -> h_sync/v_sync are bitwise inverse of the previous run; avr unchanged.
- ce toggling 1,0,1,0 -> outputs change only after ce=1 edges; frame period 256 clks; pulses last 2 clks.
- FETCH_LAT=3, ce=1 -> avr rises exactly 3 clks after fetch_avr on every visible line; pixel_num=3 in the clk where avr first rises on a line.
- Assert rst_n=0 at hc=5, vc=2 for 2 clks -> next clk after release pixel_num=1 (first ce increment from 0), syncs inactive, no h_sync glitch.
- Default parameters, ce=1 -> 1328x806 = 1,070,368 clks per frame_start; 768 line_start pulses with avr active per frame.
